// File: rtl/shifting.sv
// 32-bit barrel shifter (SLL/SRL/SRA and variable forms) for the EX stage.
// A single right-shift core serves both directions: left shifts reverse the
// operand on the way in and the result on the way out. An optional output
// register with a valid flag supports pipelined use.
module shifting #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] Din,
    input  logic [SHW-1:0]   shamt,
    input  logic             left,
    input  logic             arith,
    input  logic             en,
    output logic [WIDTH-1:0] Dout,
    output logic [WIDTH-1:0] Dout_q,
    output logic             vld_q
);

    logic [WIDTH-1:0] w_core_in;
    logic [WIDTH-1:0] w_core_out;
    logic             w_fill;
    logic [WIDTH-1:0] w_stage [0:SHW];

    // Sign fill applies only to arithmetic right shifts; left shifts and
    // logical right shifts fill the vacated positions with zeros.
    assign w_fill = arith & ~left & Din[WIDTH-1];

    // Reverse the operand for left shifts so that the core only shifts right.
    always_comb begin
        w_core_in = Din;
        if (left) begin
            for (int i = 0; i < WIDTH; i++) begin
                w_core_in[i] = Din[WIDTH-1-i];
            end
        end
    end

    assign w_stage[0] = w_core_in;

    // One mux stage per shamt bit; stage k shifts right by 2^k when shamt[k] is set.
    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int SH = 1 << k;
        assign w_stage[k+1] = shamt[k]
            ? {{SH{w_fill}}, w_stage[k][WIDTH-1:SH]}
            : w_stage[k];
    end

    assign w_core_out = w_stage[SHW];

    // Undo the operand reversal for left shifts.
    always_comb begin
        Dout = w_core_out;
        if (left) begin
            for (int i = 0; i < WIDTH; i++) begin
                Dout[i] = w_core_out[WIDTH-1-i];
            end
        end
    end

    // Output register: capture the combinational result when en is set;
    // vld_q simply tracks en one cycle late.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Dout_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= en;
            if (en) begin
                Dout_q <= Dout;
            end
        end
    end

endmodule

// File: tb/tb_shifting.sv
// Directed bench for shifting: combinational shift vectors plus output register checks.
module tb_shifting;

    logic        clk;
    logic        rst;
    logic [31:0] Din;
    logic [4:0]  shamt;
    logic        left;
    logic        arith;
    logic        en;
    logic [31:0] Dout;
    logic [31:0] Dout_q;
    logic        vld_q;

    int n_cmp;
    int n_bad;

    shifting #(.WIDTH(32), .SHW(5)) dut (
        .clk    (clk),
        .rst    (rst),
        .Din    (Din),
        .shamt  (shamt),
        .left   (left),
        .arith  (arith),
        .en     (en),
        .Dout   (Dout),
        .Dout_q (Dout_q),
        .vld_q  (vld_q)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic vec(input string tag, input logic [31:0] d, input logic [4:0] s,
                       input logic l, input logic a, input logic [31:0] exp);
        Din   = d;
        shamt = s;
        left  = l;
        arith = a;
        #1;
        chk(tag, Dout, exp);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        en    = 1'b0;
        Din   = 32'h0;
        shamt = 5'd0;
        left  = 1'b0;
        arith = 1'b0;

        // Reset state before any clock edge
        #1;
        chk("rst_dout_q", Dout_q, 32'h0);
        chk("rst_vld_q", {31'b0, vld_q}, 32'h0);

        // Combinational vectors
        vec("sll4",        32'h0FF0F00F, 5'd4,  1'b1, 1'b0, 32'hFF0F00F0);
        vec("srl4",        32'h0FF0F00F, 5'd4,  1'b0, 1'b0, 32'h00FF0F00);
        vec("sll2",        32'h24345518, 5'd2,  1'b1, 1'b0, 32'h90D15460);
        vec("sra4_neg",    32'hF0000000, 5'd4,  1'b0, 1'b1, 32'hFF000000);
        vec("srl4_neg",    32'hF0000000, 5'd4,  1'b0, 1'b0, 32'h0F000000);
        vec("sll31",       32'h00000001, 5'd31, 1'b1, 1'b0, 32'h80000000);
        vec("sra31",       32'h80000000, 5'd31, 1'b0, 1'b1, 32'hFFFFFFFF);
        vec("srl31",       32'h80000000, 5'd31, 1'b0, 1'b0, 32'h00000001);
        vec("sh0_l",       32'hDEADBEEF, 5'd0,  1'b1, 1'b0, 32'hDEADBEEF);
        vec("sh0_la",      32'hDEADBEEF, 5'd0,  1'b1, 1'b1, 32'hDEADBEEF);
        vec("sh0_r",       32'hDEADBEEF, 5'd0,  1'b0, 1'b0, 32'hDEADBEEF);
        vec("sh0_ra",      32'hDEADBEEF, 5'd0,  1'b0, 1'b1, 32'hDEADBEEF);
        vec("sra4_pos",    32'h70000000, 5'd4,  1'b0, 1'b1, 32'h07000000);
        vec("sll1_arith",  32'h80000001, 5'd1,  1'b1, 1'b1, 32'h00000002);
        vec("sra16",       32'h80001234, 5'd16, 1'b0, 1'b1, 32'hFFFF8000);
        vec("sll16",       32'h0000ABCD, 5'd16, 1'b1, 1'b0, 32'hABCD0000);
        vec("srl7",        32'h12345678, 5'd7,  1'b0, 1'b0, 32'h002468AC);
        vec("srl7_arithp", 32'h12345678, 5'd7,  1'b0, 1'b1, 32'h002468AC);

        // Register: release reset away from an edge, then capture with en=1
        @(negedge clk);
        rst = 1'b0;
        Din = 32'h0FF0F00F; shamt = 5'd4; left = 1'b1; arith = 1'b0;
        en  = 1'b1;
        @(posedge clk); #1;
        chk("cap_dout_q", Dout_q, 32'hFF0F00F0);
        chk("cap_vld_q", {31'b0, vld_q}, 32'h1);

        // en=0: value holds, valid drops
        @(negedge clk);
        Din = 32'h12345678; shamt = 5'd7; left = 1'b0;
        en  = 1'b0;
        @(posedge clk); #1;
        chk("hold_dout_q", Dout_q, 32'hFF0F00F0);
        chk("hold_vld_q", {31'b0, vld_q}, 32'h0);
        chk("hold_dout", Dout, 32'h002468AC);

        // Second capture picks up the new combinational result
        @(negedge clk);
        en = 1'b1;
        @(posedge clk); #1;
        chk("cap2_dout_q", Dout_q, 32'h002468AC);
        chk("cap2_vld_q", {31'b0, vld_q}, 32'h1);

        // Mid-stream reset clears both registers immediately; Dout unaffected
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst_dout_q", Dout_q, 32'h0);
        chk("mrst_vld_q", {31'b0, vld_q}, 32'h0);
        chk("mrst_dout", Dout, 32'h002468AC);

        // Reset wins over en across an edge
        @(posedge clk); #1;
        chk("rstpri_dout_q", Dout_q, 32'h0);
        chk("rstpri_vld_q", {31'b0, vld_q}, 32'h0);

        // Recover after reset
        @(negedge clk);
        rst = 1'b0;
        Din = 32'h80000000; shamt = 5'd31; left = 1'b0; arith = 1'b1;
        @(posedge clk); #1;
        chk("rec_dout_q", Dout_q, 32'hFFFFFFFF);
        chk("rec_vld_q", {31'b0, vld_q}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
